// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NumReq byte-stream requesters.
// A grant stays locked to one requester until its last byte, or until the hold timeout expires.
module uart_tx_arbiter #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned HoldTimeout = 1024,
  localparam int unsigned IdW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumReq-1:0]   req_valid_i,
  input  logic [8*NumReq-1:0] req_data_i,
  input  logic [NumReq-1:0]   req_last_i,
  output logic [NumReq-1:0]   req_ready_o,
  output logic [7:0]          data_tx_o,
  output logic                data_tx_valid_o,
  input  logic                active_tx_i,
  input  logic                done_tx_i,
  output logic [IdW-1:0]      grant_id_o,
  output logic                busy_o
);

  localparam int unsigned CntW = (HoldTimeout > 1) ? $clog2(HoldTimeout) : 1;

  typedef enum logic [1:0] {StIdle, StSend, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    grant_q, grant_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]        data_q, data_d;
  logic              last_q, last_d;
  logic [CntW-1:0]   hold_cnt_q, hold_cnt_d;
  logic              valid_q, valid_d;
  logic [NumReq-1:0] ready_q, ready_d;

  logic [7:0]        req_bytes [NumReq];
  logic              pick_found;
  logic [IdW-1:0]    pick_id;
  logic [IdW-1:0]    scan_id;
  int unsigned       scan_idx;
  logic [IdW-1:0]    next_ptr;

  // Frame progress is tracked through done_tx_i alone; active_tx_i is status only.
  logic unused_active_tx;
  assign unused_active_tx = active_tx_i;

  for (genvar g = 0; g < NumReq; g++) begin : g_bytes
    assign req_bytes[g] = req_data_i[8*g +: 8];
  end

  // First valid requester at or after rr_ptr_q, wrapping at NumReq.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_id    = '0;
    scan_idx   = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      scan_idx = (32'(rr_ptr_q) + i) % NumReq;
      scan_id  = IdW'(scan_idx);
      if (!pick_found && req_valid_i[scan_id]) begin
        pick_found = 1'b1;
        pick_id    = scan_id;
      end
    end
  end

  assign next_ptr = (grant_q == IdW'(NumReq - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    data_d     = data_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    valid_d    = 1'b0;
    ready_d    = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d          = pick_id;
          data_d           = req_bytes[pick_id];
          last_d           = req_last_i[pick_id];
          valid_d          = 1'b1;
          ready_d[pick_id] = 1'b1;
          state_d          = StSend;
        end
      end
      StSend: state_d = StWait;
      StWait: begin
        if (done_tx_i) begin
          if (last_q) begin
            state_d  = StIdle;
            rr_ptr_d = next_ptr;
          end else begin
            state_d    = StHold;
            hold_cnt_d = '0;
          end
        end
      end
      StHold: begin
        // Locked: only the current owner may continue its message.
        if (req_valid_i[grant_q]) begin
          data_d           = req_bytes[grant_q];
          last_d           = req_last_i[grant_q];
          valid_d          = 1'b1;
          ready_d[grant_q] = 1'b1;
          state_d          = StSend;
        end else if (hold_cnt_q == CntW'(HoldTimeout - 1)) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      hold_cnt_q <= '0;
      valid_q    <= 1'b0;
      ready_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      data_q     <= data_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
    end
  end

  assign req_ready_o     = ready_q;
  assign data_tx_o       = data_q;
  assign data_tx_valid_o = valid_q;
  assign grant_id_o      = grant_q;
  assign busy_o          = (state_q != StIdle);

endmodule
